bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the six-digit dynamic seven-segment scan driver. It takes a 20-bit unsigned value from the counter or measurement logic and converts it with shift-add-3 (double dabble), one bit per clock, under a start/busy/done handshake. It presents six packed BCD digits, an overflow flag and a per-digit enable mask, all held stable for the scan driver between conversions.

## Interface
- `BIN_W`, default 20: width of the binary input.
- `DIGITS`, default 6: number of BCD digits produced; equals the display digit count.
- `sys_clk` input 1: system clock, 50 MHz.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: conversion request, level-sampled in IDLE only.
- `bin` input BIN_W: unsigned value to convert, sampled on the accepting edge.
- `busy` output 1: high from the accepting edge until the done edge; low in IDLE.
- `done` output 1: single-cycle pulse; `bcd`, `ovf` and `digit_en` update on the same edge.
- `bcd` output 4*DIGITS: packed BCD; digit 0 (units) is in [3:0], digit 5 is in [23:20].
- `ovf` output 1: high when the last converted input exceeded MAX_VAL.
- `digit_en` output DIGITS: per-digit display enable, same bit order as `bcd`.

## Operation
- MAX_VAL = 10^DIGITS − 1, which is 999999 at the default parameters.
- State machine: IDLE → LOAD → SHIFT → DONE → IDLE.
- IDLE:
  - `start` high on an edge accepts the request.
  - `bin` is captured into the shift register and the state moves to LOAD.
- LOAD:
  - If the captured value > MAX_VAL, it is replaced by MAX_VAL and the internal overflow bit is set.
  - Otherwise the overflow bit is cleared.
  - The BCD accumulator is cleared, the bit counter is set to BIN_W, and the state moves to SHIFT.
- SHIFT, once per cycle for BIN_W cycles:
  - Every 4-bit digit ≥ 5 gets +3.
  - The {accumulator, binary} pair is then shifted left by 1.
  - The counter decrements; at counter = 1, the state moves to DONE.
- DONE:
  - `done` = 1 for this cycle.
  - `bcd`, `ovf` and `digit_en` are registered from the accumulator.
  - The state returns to IDLE unconditionally.
- `start` outside IDLE is ignored, with no queueing. `start` held high re-triggers a new conversion on the edge after DONE.
- Output registers hold their value between DONE pulses and are never partially updated.
- Arithmetic:
  - The +3 adjust is applied to a digit value in the range 5..9 only, so it never carries out of the digit.
  - The accumulator is 4*DIGITS bits wide and bits shifted out of the top are discarded; the clamp guarantees none are nonzero.
- Reset, asserted at any time including mid-SHIFT:
  - Immediately forces IDLE.
  - Clears `busy`, `done`, `ovf`, `bcd` (= 0) and all internal registers.
  - `digit_en` resets to a value with only bit 0 set.
  - No `done` pulse is produced for an aborted conversion.

## Timing
- The request is accepted on edge k; `busy` is high from edge k.
- The LOAD state is active during the cycle following edge k.
- SHIFT occupies BIN_W cycles.
- `done` is high for one cycle beginning at edge k+BIN_W+2, which is k+22 at the default parameters, and `busy` falls on that same edge.
- The earliest next accept is edge k+BIN_W+3.
- Throughput is one conversion per BIN_W+3 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `BIN2BCD_LZ_BLANK_EN` defined:
  - `digit_en[i]` = 1 if digit i or any higher digit of the new `bcd` is nonzero.
  - `digit_en[0]` is always 1, so the value 0 shows a single "0".
- Macro undefined:
  - `digit_en` is all ones (6'h3F) at all times after reset and in every DONE cycle.
  - Under reset it follows the reset rule above.

## Structure
- Package `bin2bcd_pkg`:
  - BIN_W and DIGITS defaults.
  - MAX_VAL constant.
  - State enum (IDLE, LOAD, SHIFT, DONE).
  - Counter width $clog2(BIN_W+1).
- Sub-module `bcd_add3`:
  - Combinational 4-bit "≥5 then +3" adjust.
  - Instantiated DIGITS times in a generate loop.

## Test plan
- `bin` = 0, start pulse:
  - `done` fires at 22 cycles.
  - `bcd` = 24'h000000, `ovf` = 0.
  - `digit_en` = 6'b000001 with the LZ macro, 6'b111111 without.
- `bin` = 123456 → `bcd` = 24'h123456, `ovf` = 0, `digit_en` = 6'b111111.
- `bin` = 1048575 (all ones) → `bcd` = 24'h999999, `ovf` = 1.
  - A following conversion of `bin` = 9 → `bcd` = 24'h000009, `ovf` = 0, `digit_en` = 6'b000001 (LZ).
- `start` re-pulsed at cycles 5 and 15 of a conversion of `bin` = 4321:
  - Exactly one `done`, at cycle 22, with `bcd` = 24'h004321.
  - `busy` stays high throughout.
- `sys_rst_n` dropped at cycle 10 of a conversion of `bin` = 999999:
  - Immediately `busy` = 0 and `bcd` = 0.
  - No `done` pulse.
  - A fresh conversion after release completes normally with 24'h999999.
- `start` held high for 100 cycles with `bin` = 500 → a `done` pulse every 23 cycles, each with `bcd` = 24'h000500.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared defaults, state encoding and constants for the
// sequential binary-to-BCD converter.
//   BIN_W_DEF  : default binary input width
//   DIGITS_DEF : default BCD digit count (matches the display)
//   MAX_VAL    : largest value representable in DIGITS_DEF digits
//   CNT_W      : bit-counter width at the default BIN_W
//   state_t    : converter FSM states
package bin2bcd_pkg;

  localparam int BIN_W_DEF  = 20;
  localparam int DIGITS_DEF = 6;

  // 10^digits - 1, computed wide so any sane parameterisation fits
  function automatic logic [63:0] max_val(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DIGITS_DEF);
  localparam int          CNT_W   = $clog2(BIN_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: combinational double-dabble digit adjust.
//   i_d : one BCD digit of the accumulator
//   o_d : i_d + 3 when i_d >= 5, else i_d unchanged
// Only digit values 5..9 reach the +3 path in a correct conversion, so
// the result always fits in four bits.
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary-to-BCD converter feeding the
// six-digit seven-segment scan driver. One input bit is consumed per clock.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   start     : conversion request, sampled only while idle
//   bin       : unsigned input, captured on the accepting edge
//   busy      : high from accept until the done edge
//   done      : one-cycle pulse; bcd/ovf/digit_en update on the same edge
//   bcd       : packed BCD, digit 0 (units) in [3:0]
//   ovf       : last input exceeded 10^DIGITS-1 (result clamped)
//   digit_en  : per-digit display enable, same order as bcd
// Optional feature macro: BIN2BCD_LZ_BLANK_EN enables leading-zero blanking
// on digit_en; without it every digit is enabled after each conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int          ACC_W = 4 * DIGITS;
  localparam int          CW    = $clog2(BIN_W + 1);
  localparam logic [63:0] L_MAX = max_val(DIGITS);

  state_t              r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [ACC_W-1:0]    r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf_int;
  logic                r_busy;
  logic                r_done;
  logic [ACC_W-1:0]    r_bcd;
  logic                r_ovf;
  logic [DIGITS-1:0]   r_den;

  logic [ACC_W-1:0]    w_adj;
  logic                w_over;
  logic [DIGITS-1:0]   w_den;

  // per-digit adjust ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_d (r_acc[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  assign w_over = (64'(r_bin) > L_MAX);

`ifdef BIN2BCD_LZ_BLANK_EN
  // digit i lit if it or any higher digit is nonzero; units always lit
  always_comb begin
    w_den = '0;
    for (int i = 0; i < DIGITS; i++) w_den[i] = |(r_acc >> (4 * i));
    w_den[0] = 1'b1;
  end
`else
  assign w_den = '1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_den     <= DIGITS'(1);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // clamp so no nonzero bit is ever shifted out of the accumulator
          if (w_over) r_bin <= BIN_W'(L_MAX);
          r_ovf_int <= w_over;
          r_acc     <= '0;
          r_cnt     <= CW'(BIN_W);
          r_state   <= SHIFT;
        end
        SHIFT: begin
          r_acc <= {w_adj[ACC_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          // all result registers load together on the done edge
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_bcd   <= r_acc;
          r_ovf   <= r_ovf_int;
          r_den   <= w_den;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign ovf      = r_ovf;
  assign digit_en = r_den;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [19:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        ovf;
  logic [5:0]  digit_en;

  int n_vec;
  int n_err;

  bin2bcd_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .ovf       (ovf),
    .digit_en  (digit_en)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [5:0] DE_0    = 6'b000001;
  localparam logic [5:0] DE_9    = 6'b000001;
  localparam logic [5:0] DE_4321 = 6'b001111;
  localparam logic [5:0] DE_500  = 6'b000111;
`else
  localparam logic [5:0] DE_0    = 6'b111111;
  localparam logic [5:0] DE_9    = 6'b111111;
  localparam logic [5:0] DE_4321 = 6'b111111;
  localparam logic [5:0] DE_500  = 6'b111111;
`endif

  // Stimulus helper: one start pulse, then watch cyc edges after accept.
  task automatic run_conv(input logic [19:0] v, input int cyc,
                          output int first_done, output int ndone,
                          output logic busy_at_k);
    @(negedge sys_clk);
    bin   = v;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start      = 1'b0;
    busy_at_k  = busy;
    first_done = -1;
    ndone      = 0;
    for (int n = 1; n <= cyc; n++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    bin       = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 24'h0 || ovf !== 1'b0 ||
        digit_en !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b de=%b, want 0 0 000000 0 000001",
               busy, done, bcd, ovf, digit_en);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int fd, nd; logic bk;
    run_conv(20'd0, 26, fd, nd, bk);
    n_vec++;
    if (bk !== 1'b1) begin
      n_err++; $display("FAIL zero_busy_at_accept: got %b want 1", bk);
    end
    n_vec++;
    if (fd !== 22 || nd !== 1) begin
      n_err++; $display("FAIL zero_done_timing: first=%0d count=%0d want 22 1", fd, nd);
    end
    n_vec++;
    if (bcd !== 24'h000000 || ovf !== 1'b0 || digit_en !== DE_0) begin
      n_err++; $display("FAIL zero_result: bcd=%h ovf=%b de=%b want 000000 0 %b", bcd, ovf, digit_en, DE_0);
    end
  endtask

  task automatic test_value();
    int fd, nd; logic bk;
    run_conv(20'd123456, 26, fd, nd, bk);
    n_vec++;
    if (fd !== 22 || nd !== 1) begin
      n_err++; $display("FAIL val_done_timing: first=%0d count=%0d want 22 1", fd, nd);
    end
    n_vec++;
    if (bcd !== 24'h123456 || ovf !== 1'b0 || digit_en !== 6'b111111) begin
      n_err++; $display("FAIL val_123456: bcd=%h ovf=%b de=%b want 123456 0 111111", bcd, ovf, digit_en);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL val_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_overflow();
    int fd, nd; logic bk;
    run_conv(20'hFFFFF, 26, fd, nd, bk);
    n_vec++;
    if (bcd !== 24'h999999 || ovf !== 1'b1 || digit_en !== 6'b111111) begin
      n_err++; $display("FAIL ovf_clamp: bcd=%h ovf=%b de=%b want 999999 1 111111", bcd, ovf, digit_en);
    end
    run_conv(20'd9, 26, fd, nd, bk);
    n_vec++;
    if (bcd !== 24'h000009 || ovf !== 1'b0 || digit_en !== DE_9) begin
      n_err++; $display("FAIL after_ovf_9: bcd=%h ovf=%b de=%b want 000009 0 %b", bcd, ovf, digit_en, DE_9);
    end
    // exact boundary: 999999 is not an overflow
    run_conv(20'd999999, 26, fd, nd, bk);
    n_vec++;
    if (bcd !== 24'h999999 || ovf !== 1'b0) begin
      n_err++; $display("FAIL max_val: bcd=%h ovf=%b want 999999 0", bcd, ovf);
    end
    run_conv(20'd1000000, 26, fd, nd, bk);
    n_vec++;
    if (bcd !== 24'h999999 || ovf !== 1'b1) begin
      n_err++; $display("FAIL max_plus1: bcd=%h ovf=%b want 999999 1", bcd, ovf);
    end
  endtask

  task automatic test_restart_ignored();
    int fd, nd, busy_drop;
    fd = -1; nd = 0; busy_drop = 0;
    @(negedge sys_clk);
    bin   = 20'd4321;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    bin   = 20'd777;
    for (int n = 1; n <= 28; n++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        nd++;
        if (fd < 0) fd = n;
      end
      if (n < 22 && busy !== 1'b1) busy_drop++;
      start = (n == 4 || n == 14);
    end
    n_vec++;
    if (fd !== 22 || nd !== 1) begin
      n_err++; $display("FAIL restart_done: first=%0d count=%0d want 22 1", fd, nd);
    end
    n_vec++;
    if (busy_drop !== 0) begin
      n_err++; $display("FAIL restart_busy: low cycles=%0d want 0", busy_drop);
    end
    n_vec++;
    if (bcd !== 24'h004321 || digit_en !== DE_4321) begin
      n_err++; $display("FAIL restart_bcd: bcd=%h de=%b want 004321 %b", bcd, digit_en, DE_4321);
    end
  endtask

  task automatic test_reset_abort();
    int fd, nd; logic bk;
    @(negedge sys_clk);
    bin   = 20'd999999;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || bcd !== 24'h0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL abort_reset: busy=%b bcd=%h done=%b ovf=%b want 0 000000 0 0", busy, bcd, done, ovf);
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge sys_clk);
      #1;
      if (done) nd++;
    end
    n_vec++;
    if (nd !== 0) begin
      n_err++; $display("FAIL abort_no_done: pulses=%0d want 0", nd);
    end
    run_conv(20'd999999, 26, fd, nd, bk);
    n_vec++;
    if (fd !== 22 || bcd !== 24'h999999 || ovf !== 1'b0) begin
      n_err++; $display("FAIL abort_recover: first=%0d bcd=%h ovf=%b want 22 999999 0", fd, bcd, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int nd, last, bad_gap, bad_val, first;
    nd = 0; last = -1; bad_gap = 0; bad_val = 0; first = -1;
    @(negedge sys_clk);
    bin   = 20'd500;
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        nd++;
        if (first < 0) first = n;
        if (last >= 0 && (n - last) != 23) bad_gap++;
        if (bcd !== 24'h000500 || digit_en !== DE_500) bad_val++;
        last = n;
      end
    end
    start = 1'b0;
    repeat (30) @(posedge sys_clk);
    n_vec++;
    if (nd !== 4 || first !== 23) begin
      n_err++; $display("FAIL b2b_count: pulses=%0d first=%0d want 4 23", nd, first);
    end
    n_vec++;
    if (bad_gap !== 0) begin
      n_err++; $display("FAIL b2b_period: bad gaps=%0d want 0", bad_gap);
    end
    n_vec++;
    if (bad_val !== 0) begin
      n_err++; $display("FAIL b2b_value: bad results=%0d want 0", bad_val);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_zero();
    test_value();
    test_overflow();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
